// File: rtl/pong_math_pkg.sv
// Shared constants, FSM state type and dividend helper for the angle-conversion datapath.
package pong_math_pkg;

  localparam logic [31:0] PI_Q30      = 32'hC90FDAA2;
  localparam int          DIV_ITERS   = 8;
  localparam int          CNT_W       = $clog2(DIV_ITERS);
  localparam logic [39:0] HALF_PI_Q30 = 40'(PI_Q30 >> 1);
  localparam logic [7:0]  RANGE_LIMIT = 8'd90;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_e;

  // |rad| * 180 + pi/2 so that the truncating divide rounds half away from zero.
  function automatic logic [39:0] make_dividend(input logic [31:0] rad);
    logic [31:0] mag;
    mag = rad[31] ? (~rad + 32'd1) : rad;
    return ({8'd0, mag} * 40'd180) + HALF_PI_Q30;
  endfunction

endpackage

// File: rtl/rad_to_deg_if.sv
// Input/output handshake bundle for the radian-to-degree converter.
interface rad_to_deg_if;
  logic [31:0] rad;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] deg;
  logic        out_of_range;
  logic        out_valid;
  logic        out_ready;

  modport slave (
    input  rad, in_valid, out_ready,
    output in_ready, deg, out_of_range, out_valid
  );

  modport master (
    output rad, in_valid, out_ready,
    input  in_ready, deg, out_of_range, out_valid
  );
endinterface

// File: rtl/rad_to_deg_div_step.sv
// One restoring-divide step: trial subtract, keep the difference when it is non-negative.
module div_step (
  input  logic [32:0] rem_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic        q_bit_o
);
  logic [32:0] diff;

  // rem_i < 2*divisor, so the 33-bit difference never overflows and bit 32 is its sign.
  always_comb begin
    diff    = rem_i - {1'b0, divisor_i};
    q_bit_o = ~diff[32];
    rem_o   = q_bit_o ? diff[31:0] : rem_i[31:0];
  end
endmodule

// File: rtl/rad_to_deg.sv
// Converts a Q2.30 radian angle to rounded signed integer degrees via an 8-cycle restoring divide.
module rad_to_deg
  import pong_math_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  rad_to_deg_if.slave  bus
);
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       iter_q;
  logic [32:0]            rem_q;
  logic [DIV_ITERS-2:0]   lo_q;
  logic [DIV_ITERS-2:0]   quot_q;
  logic                   sign_q;
  logic [31:0]            deg_q;
  logic                   oor_q;

  logic                   accept;
  logic                   last_iter;
  logic [39:0]            dividend;
  logic [31:0]            step_rem;
  logic                   step_q;
  logic [DIV_ITERS-1:0]   quot_next;
  logic [31:0]            quot_ext;
  logic [31:0]            deg_d;

  assign accept    = bus.in_valid && (state_q == IDLE);
  assign last_iter = (state_q == DIVIDE) && (iter_q == CNT_W'(DIV_ITERS - 1));
  assign dividend  = make_dividend(bus.rad);
  assign quot_next = {quot_q, step_q};
  assign quot_ext  = {24'd0, quot_next};
  assign deg_d     = sign_q ? (32'd0 - quot_ext) : quot_ext;

  div_step u_div_step (
    .rem_i     (rem_q),
    .divisor_i (PI_Q30),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = DIVIDE;
      DIVIDE:  if (last_iter)     state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // The dividend is split: bits [39:7] seed the partial remainder, [6:0] are shifted in one per step.
  always_ff @(posedge clk) begin
    if (reset) begin
      iter_q <= '0;
      rem_q  <= '0;
      lo_q   <= '0;
      quot_q <= '0;
      sign_q <= 1'b0;
      deg_q  <= '0;
      oor_q  <= 1'b0;
    end else if (accept) begin
      sign_q <= bus.rad[31];
      rem_q  <= dividend[39:7];
      lo_q   <= dividend[6:0];
      quot_q <= '0;
      iter_q <= '0;
    end else if (state_q == DIVIDE) begin
      rem_q  <= {step_rem, lo_q[DIV_ITERS-2]};
      lo_q   <= {lo_q[DIV_ITERS-3:0], 1'b0};
      quot_q <= quot_next[DIV_ITERS-2:0];
      iter_q <= iter_q + CNT_W'(1);
      if (last_iter) begin
        deg_q <= deg_d;
        oor_q <= (quot_next > RANGE_LIMIT);
      end
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.deg          = deg_q;
  assign bus.out_of_range = oor_q;
endmodule

// File: tb/tb_rad_to_deg.sv
// Directed plus randomized bench for rad_to_deg against an integer-arithmetic reference.
module tb_rad_to_deg;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rad_to_deg_if bus_if ();

  rad_to_deg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // Reference: round(|rad| * 180 / pi_q30) with ties away from zero, then reapply the sign.
  function automatic logic [31:0] model_deg(input logic [31:0] r, output logic oor);
    longint unsigned pi_q30;
    longint unsigned mag;
    longint unsigned q;
    logic [31:0]     q32;
    pi_q30 = 64'd3373259426;
    mag    = r[31] ? (64'h1_0000_0000 - {32'd0, r}) : {32'd0, r};
    q      = (mag * 180 + pi_q30 / 2) / pi_q30;
    q32    = q[31:0];
    oor    = (q > 90);
    return r[31] ? (32'd0 - q32) : q32;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
               tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  // Called at a negedge while IDLE; returns at the negedge after the acceptance edge.
  task automatic start(input logic [31:0] r);
    bus_if.rad      = r;
    bus_if.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    bus_if.rad      = $urandom;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (bus_if.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_out();
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.out_ready = 1'b0;
  endtask

  task automatic convert(input string tag, input logic [31:0] r,
                         input logic [31:0] exp_deg, input logic exp_oor);
    int lat;
    check({tag, ".in_ready"}, 32'(bus_if.in_ready), 32'd1);
    start(r);
    wait_out(lat);
    check({tag, ".latency"}, 32'(lat), 32'd8);
    check({tag, ".deg"}, bus_if.deg, exp_deg);
    check({tag, ".oor"}, 32'(bus_if.out_of_range), 32'(exp_oor));
    $display("conv %s rad=%08h deg=%0d oor=%0d lat=%0d",
             tag, r, $signed(bus_if.deg), bus_if.out_of_range, lat);
    release_out();
    check({tag, ".idle"}, 32'(bus_if.out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] e;
    logic        eo;
    int          lat;

    reset            = 1'b1;
    bus_if.rad       = '0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst.in_ready", 32'(bus_if.in_ready), 32'd1);
    check("rst.out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst.deg", bus_if.deg, 32'd0);
    check("rst.oor", 32'(bus_if.out_of_range), 32'd0);

    convert("zero", 32'h00000000, 32'd0, 1'b0);
    convert("p90", 32'h6487ED51, 32'd90, 1'b0);
    convert("m90", 32'h9B7812AF, -32'sd90, 1'b0);
    convert("p45", 32'h3243F6A9, 32'd45, 1'b0);
    convert("p15", 32'h10C15238, 32'd15, 1'b0);
    convert("max", 32'h7FFFFFFF, 32'd115, 1'b1);
    convert("min", 32'h80000000, -32'sd115, 1'b1);
    convert("tiny_neg", 32'hFFFFFFFF, 32'd0, 1'b0);

    // Backpressure: hold the result for five cycles while a new request is offered.
    start(32'h3243F6A9);
    wait_out(lat);
    check("bp.latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.rad      = 32'h6487ED51;
      check("bp.deg", bus_if.deg, 32'd45);
      check("bp.in_ready", 32'(bus_if.in_ready), 32'd0);
      check("bp.out_valid", 32'(bus_if.out_valid), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    bus_if.in_valid = 1'b0;
    release_out();
    check("bp.release_in_ready", 32'(bus_if.in_ready), 32'd1);
    check("bp.release_out_valid", 32'(bus_if.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("bp.stays_idle", 32'(bus_if.in_ready), 32'd1);
    $display("conv backpressure done");

    // Reset sampled on the edge that ends the fourth DIVIDE cycle.
    start(32'h7FFFFFFF);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrst.in_ready", 32'(bus_if.in_ready), 32'd1);
    check("midrst.out_valid", 32'(bus_if.out_valid), 32'd0);
    check("midrst.deg", bus_if.deg, 32'd0);
    $display("conv midreset done");
    convert("after_rst", 32'h3243F6A9, 32'd45, 1'b0);

    // Back-to-back: second request presented on the handoff cycle.
    r = $urandom;
    e = model_deg(r, eo);
    start(r);
    wait_out(lat);
    check("b2b.a_latency", 32'(lat), 32'd8);
    check("b2b.a_deg", bus_if.deg, e);
    check("b2b.a_oor", 32'(bus_if.out_of_range), 32'(eo));
    $display("conv b2b_a rad=%08h deg=%0d", r, $signed(bus_if.deg));
    r = $urandom;
    e = model_deg(r, eo);
    bus_if.out_ready = 1'b1;
    bus_if.in_valid  = 1'b1;
    bus_if.rad       = r;
    @(posedge clk);
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    check("b2b.gap_in_ready", 32'(bus_if.in_ready), 32'd1);
    check("b2b.gap_out_valid", 32'(bus_if.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    bus_if.rad      = $urandom;
    wait_out(lat);
    check("b2b.b_latency", 32'(lat), 32'd8);
    check("b2b.b_deg", bus_if.deg, e);
    check("b2b.b_oor", 32'(bus_if.out_of_range), 32'(eo));
    $display("conv b2b_b rad=%08h deg=%0d", r, $signed(bus_if.deg));
    release_out();

    for (int i = 0; i < 24; i++) begin
      r = $urandom;
      e = model_deg(r, eo);
      convert($sformatf("rnd%0d", i), r, e, eo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rad_to_deg.md
RAD_TO_DEG -- requirements
Module: rad_to_deg

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rad  input  32  radian angle, fixed point, 2 integer bits and 30 fraction bits, two's complement.
REQ-005 in_valid  input  1  rad is valid this cycle.
REQ-006 in_ready  output  1  block can accept an input this cycle.
REQ-007 deg  output  32  signed integer degrees, two's complement.
REQ-008 out_of_range  output  1  result magnitude is greater than 90.
REQ-009 out_valid  output  1  deg and out_of_range are valid.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.

Function
REQ-011 The block SHALL compute deg = sign(rad) * round(|rad| * 180 / pi); ties round away from zero.
REQ-012 Constant PI_Q30 SHALL be 32'hC90FDAA2 (pi * 2^30).
REQ-013 At acceptance the block SHALL register the sign bit rad[31] and the 40-bit dividend |rad| * 180 + PI_Q30/2.
REQ-014 |rad| SHALL be computed as 32-bit unsigned, so rad = 32'h80000000 gives magnitude 2^31.
REQ-015 The block SHALL implement a restoring divide of the dividend by PI_Q30.
- 8 iterations, one quotient bit per cycle, MSB first.
- 33-bit partial remainder.
- The 8-bit quotient covers the full input range; the maximum result is 115.
REQ-016 The block SHALL have FSM states IDLE, DIVIDE and DONE.
- IDLE to DIVIDE on in_valid && in_ready.
- DIVIDE to DONE after the 8th iteration.
- DONE to IDLE on out_valid && out_ready.
REQ-017 in_ready SHALL equal (state == IDLE); there is no accept in the same cycle as a result handoff.
REQ-018 out_valid SHALL equal (state == DONE) and SHALL first assert 8 clock edges after the acceptance edge.
REQ-019 deg SHALL be the quotient zero-extended, then negated when the registered sign is 1; a zero quotient SHALL give +0.
REQ-020 out_of_range SHALL be 1 when the quotient is greater than 90; deg is still produced.
REQ-021 deg and out_of_range SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 in_valid while not in IDLE SHALL be ignored, and rad changes during DIVIDE SHALL NOT affect the result.

Reset
REQ-023 Reset SHALL take priority over every other event and abort any DIVIDE or DONE in progress.
REQ-024 Values after reset: state=IDLE, in_ready=1, out_valid=0, deg=0, out_of_range=0, iteration counter=0, remainder=0.

Structure
REQ-025 PI_Q30, the iteration count 8 and the FSM state enum SHALL live in the shared package pong_math_pkg.
REQ-026 One sub-module, div_step, SHALL be combinational and perform a single restoring-divide step.
- Inputs: remainder and divisor.
- Outputs: next remainder and quotient bit.
REQ-027 All other logic SHALL sit in rad_to_deg.
REQ-028 The RTL SHALL contain no combinational `/` operator.

Verification
REQ-029 Zero: rad=32'h00000000 -> deg=0, out_of_range=0, out_valid 8 edges after acceptance.
REQ-030 Table values, each must be exact:
- 32'h6487ED51 -> 90
- 32'h9B7812AF -> -90
- 32'h3243F6A9 -> 45
- 32'h10C15238 -> 15
REQ-031 Range limits:
- 32'h7FFFFFFF -> deg=115, out_of_range=1.
- 32'h80000000 -> deg=-115, out_of_range=1.
REQ-032 Backpressure: out_ready=0 for 5 cycles after out_valid.
- deg stays stable and in_ready=0 throughout.
- A new in_valid in that window is ignored.
- out_ready=1 -> IDLE on the next edge.
REQ-033 Reset mid-operation: assert reset on the 4th DIVIDE cycle.
- Next cycle: in_ready=1, out_valid=0, deg=0.
- The next conversion, 32'h3243F6A9, returns 45.
REQ-034 Back-to-back: a second input is presented the cycle out_ready is accepted.
- It is accepted one cycle later.
- Both results are correct.
